// File: rtl/cpu_dma_queue_mc.sv
// cpu_dma_queue_mc: per-queue RX/TX FWFT packet FIFO pairs shared by one DMA engine
// Ports: clk, reset (async active-low); in_* user->RX FIFOs, in_rdy RX space;
//   out_* TX FIFOs->user, out_rdy downstream ready; cpu_q_dma_rd*/wr* DMA access by queue select;
//   cpu_q_dma_pkt_avail / cpu_q_dma_nearly_full registered status; tx_timeout / tx_timeout_total watchdog flushes.
module cpu_dma_queue_mc #(
   parameter int NUM_QUEUES          = 4,
   parameter int QSEL_WIDTH          = 2,
   parameter int DATA_WIDTH          = 64,
   parameter int CTRL_WIDTH          = DATA_WIDTH/8,
   parameter int FIFO_ADDR_WIDTH     = 9,
   parameter int ALMOST_FULL_SLACK   = 12,
   parameter int TX_WATCHDOG_TIMEOUT = 125000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
   input  logic [NUM_QUEUES-1:0]            in_wr,
   output logic [NUM_QUEUES-1:0]            in_rdy,
   output logic [NUM_QUEUES*DATA_WIDTH-1:0] out_data,
   output logic [NUM_QUEUES*CTRL_WIDTH-1:0] out_ctrl,
   output logic [NUM_QUEUES-1:0]            out_wr,
   input  logic [NUM_QUEUES-1:0]            out_rdy,
   output logic [NUM_QUEUES-1:0]            cpu_q_dma_pkt_avail,
   input  logic                             cpu_q_dma_rd,
   input  logic [QSEL_WIDTH-1:0]            cpu_q_dma_rd_qsel,
   output logic [DATA_WIDTH-1:0]            cpu_q_dma_rd_data,
   output logic [CTRL_WIDTH-1:0]            cpu_q_dma_rd_ctrl,
   output logic [NUM_QUEUES-1:0]            cpu_q_dma_nearly_full,
   input  logic                             cpu_q_dma_wr,
   input  logic [QSEL_WIDTH-1:0]            cpu_q_dma_wr_qsel,
   input  logic [DATA_WIDTH-1:0]            cpu_q_dma_wr_data,
   input  logic [CTRL_WIDTH-1:0]            cpu_q_dma_wr_ctrl,
   output logic [NUM_QUEUES-1:0]            tx_timeout,
   output logic [15:0]                      tx_timeout_total
);
   localparam int AW = FIFO_ADDR_WIDTH;
   localparam int DEPTH = 2**AW;
   localparam int W = DATA_WIDTH + CTRL_WIDTH;
   localparam int TW = $clog2(TX_WATCHDOG_TIMEOUT + 1);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] NF_LVL = (AW+1)'(DEPTH - ALMOST_FULL_SLACK);
   localparam logic [TW-1:0] WD_LOAD = TW'(TX_WATCHDOG_TIMEOUT);

   logic [DATA_WIDTH-1:0] rx_head_data [NUM_QUEUES];
   logic [CTRL_WIDTH-1:0] rx_head_ctrl [NUM_QUEUES];
   logic [16:0]           to_sum;

   genvar q;
   generate
      for (q = 0; q < NUM_QUEUES; q++) begin : g_q
         logic [W-1:0]          rx_mem [DEPTH];
         logic [W-1:0]          tx_mem [DEPTH];
         logic [AW-1:0]         rx_wp, rx_rp, tx_wp, tx_rp;
         logic [AW:0]           rx_used, tx_used, rx_cnt, tx_cnt;
         logic                  rx_prev0_wr, rx_prev0_rd, tx_prev0_rd;
         logic [TW-1:0]         timer;
         logic                  pa_r, nf_r, to_r;
         logic [W-1:0]          rx_w, tx_w, rx_head, tx_head;
         logic                  rx_wr_en, rx_rd_en, rx_eop_wr, rx_pkt_rd;
         logic                  tx_wr_en, tx_rd_en, tx_eop_wr, tx_pkt_rd, ow;
         assign rx_head = rx_mem[rx_rp];
         assign tx_head = tx_mem[tx_rp];
         always_comb begin
            rx_w = {in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH], in_data[q*DATA_WIDTH +: DATA_WIDTH]};
            tx_w = {cpu_q_dma_wr_ctrl, cpu_q_dma_wr_data};
            rx_rd_en = cpu_q_dma_rd & (cpu_q_dma_rd_qsel == QSEL_WIDTH'(q)) & (rx_used != '0);
            // a full FIFO still takes a word when the head leaves in the same cycle
            rx_wr_en = in_wr[q] & ((rx_used != FULL_LVL) | rx_rd_en);
            rx_eop_wr = rx_wr_en & (rx_w[W-1:DATA_WIDTH] != '0) & rx_prev0_wr;
            rx_pkt_rd = rx_rd_en & (rx_head[W-1:DATA_WIDTH] != '0) & rx_prev0_rd;
            ow = (tx_cnt != '0) & out_rdy[q];
            tx_rd_en = ow & (tx_used != '0);
            tx_wr_en = cpu_q_dma_wr & (cpu_q_dma_wr_qsel == QSEL_WIDTH'(q)) & ((tx_used != FULL_LVL) | tx_rd_en);
            tx_eop_wr = tx_wr_en & (cpu_q_dma_wr_ctrl != '0);
            tx_pkt_rd = tx_rd_en & (tx_head[W-1:DATA_WIDTH] != '0) & tx_prev0_rd;
         end
         always_ff @(posedge clk) begin
            if (rx_wr_en) rx_mem[rx_wp] <= rx_w;
            if (tx_wr_en) tx_mem[tx_wp] <= tx_w;
         end
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rx_wp       <= '0;
               rx_rp       <= '0;
               rx_used     <= '0;
               rx_cnt      <= '0;
               rx_prev0_wr <= 1'b0;
               rx_prev0_rd <= 1'b0;
               pa_r        <= 1'b0;
            end else begin
               rx_wp       <= rx_wp + AW'(rx_wr_en);
               rx_rp       <= rx_rp + AW'(rx_rd_en);
               rx_used     <= rx_used + (AW+1)'(rx_wr_en) - (AW+1)'(rx_rd_en);
               rx_cnt      <= rx_cnt + (AW+1)'(rx_eop_wr) - (AW+1)'(rx_pkt_rd);
               rx_prev0_wr <= rx_wr_en ? (rx_w[W-1:DATA_WIDTH] == '0) : rx_prev0_wr;
               rx_prev0_rd <= rx_rd_en ? (rx_head[W-1:DATA_WIDTH] == '0) : rx_prev0_rd;
               pa_r        <= rx_cnt != '0;
            end
         end
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               tx_wp       <= '0;
               tx_rp       <= '0;
               tx_used     <= '0;
               tx_cnt      <= '0;
               tx_prev0_rd <= 1'b0;
               timer       <= WD_LOAD;
               nf_r        <= 1'b0;
               to_r        <= 1'b0;
            end else begin
               // the flush cycle overrides any traffic on this queue
               if (to_r) begin
                  tx_wp       <= '0;
                  tx_rp       <= '0;
                  tx_used     <= '0;
                  tx_cnt      <= '0;
                  tx_prev0_rd <= 1'b0;
                  timer       <= WD_LOAD;
               end else begin
                  tx_wp       <= tx_wp + AW'(tx_wr_en);
                  tx_rp       <= tx_rp + AW'(tx_rd_en);
                  tx_used     <= tx_used + (AW+1)'(tx_wr_en) - (AW+1)'(tx_rd_en);
                  tx_cnt      <= tx_cnt + (AW+1)'(tx_eop_wr) - (AW+1)'(tx_pkt_rd);
                  tx_prev0_rd <= tx_rd_en ? (tx_head[W-1:DATA_WIDTH] == '0) : tx_prev0_rd;
                  timer       <= (tx_wr_en | ow) ? WD_LOAD :
                                 (tx_used != '0 && timer != '0) ? timer - TW'(1) : timer;
               end
               nf_r <= tx_used >= NF_LVL;
               // only a partial packet with no complete one behind it counts as stuck
               to_r <= (timer == '0) & (tx_used != '0) & (tx_cnt == '0) & ~to_r;
            end
         end
         assign in_rdy[q] = rx_used < NF_LVL;
         assign out_wr[q] = ow;
         assign out_data[q*DATA_WIDTH +: DATA_WIDTH] = tx_head[DATA_WIDTH-1:0];
         assign out_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH] = tx_head[W-1:DATA_WIDTH];
         assign rx_head_data[q] = rx_head[DATA_WIDTH-1:0];
         assign rx_head_ctrl[q] = rx_head[W-1:DATA_WIDTH];
         assign cpu_q_dma_pkt_avail[q] = pa_r;
         assign cpu_q_dma_nearly_full[q] = nf_r;
         assign tx_timeout[q] = to_r;
      end
   endgenerate

   // an unused queue select matches no queue and reads back zero
   always_comb begin
      cpu_q_dma_rd_data = '0;
      cpu_q_dma_rd_ctrl = '0;
      for (int i = 0; i < NUM_QUEUES; i++)
         if (cpu_q_dma_rd_qsel == QSEL_WIDTH'(i)) begin
            cpu_q_dma_rd_data = rx_head_data[i];
            cpu_q_dma_rd_ctrl = rx_head_ctrl[i];
         end
   end

   always_comb begin
      to_sum = {1'b0, tx_timeout_total};
      for (int i = 0; i < NUM_QUEUES; i++) to_sum = to_sum + 17'(tx_timeout[i]);
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) tx_timeout_total <= '0;
      else tx_timeout_total <= to_sum[16] ? 16'hFFFF : to_sum[15:0];
endmodule
